// File: rtl/wb_stage_arb_pkg.sv
// Shared encodings and the sub-word load extraction helper for the writeback stage.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSV  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_W   = 2'd0,
        LD_H   = 2'd1,
        LD_B   = 2'd2,
        LD_RSV = 2'd3
    } ld_size_e;

    // Widest datapath the helper supports; callers cast in and out of this width.
    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] ld_extract(
        input logic [MAX_W-1:0] word,
        input logic [1:0]       offset,
        input logic [1:0]       size,
        input logic             sign_ext
    );
        logic [7:0]       b;
        logic [15:0]      h;
        logic [MAX_W-1:0] r;
        b = word[{1'b0, offset, 3'b000} +: 8];
        h = word[{1'b0, offset[1], 4'b0000} +: 16];
        case (size)
            LD_B:    r = {{(MAX_W-8){sign_ext & b[7]}}, b};
            LD_H:    r = {{(MAX_W-16){sign_ext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_arb_if.sv
// MEM-stage slot, late-result offer and register-file write port of the writeback stage.
interface wb_stage_arb_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_alu_result;
    logic [DATA_W-1:0]  in_read_data;
    logic [DATA_W-1:0]  in_link_pc;
    logic [1:0]         in_wb_sel;
    logic               in_reg_write;
    logic [RADDR_W-1:0] in_reg_dest;
    logic [1:0]         in_ld_size;
    logic               in_ld_signed;

    logic               lr_valid;
    logic               lr_ready;
    logic [RADDR_W-1:0] lr_dest;
    logic [DATA_W-1:0]  lr_data;

    logic               wb_we;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               wb_src_late;

    modport master (
        output in_valid, in_alu_result, in_read_data, in_link_pc, in_wb_sel,
               in_reg_write, in_reg_dest, in_ld_size, in_ld_signed,
               lr_valid, lr_dest, lr_data,
        input  in_ready, lr_ready, wb_we, wb_addr, wb_data, wb_src_late
    );

    modport slave (
        input  in_valid, in_alu_result, in_read_data, in_link_pc, in_wb_sel,
               in_reg_write, in_reg_dest, in_ld_size, in_ld_signed,
               lr_valid, lr_dest, lr_data,
        output in_ready, lr_ready, wb_we, wb_addr, wb_data, wb_src_late
    );
endinterface

// File: rtl/wb_stage_arb_late_fifo.sv
// Circular buffer holding out-of-order mul/div results until the write port is free.
module wb_late_fifo #(
    parameter  int DATA_W   = 32,
    parameter  int RADDR_W  = 5,
    parameter  int LR_DEPTH = 4,
    localparam int CNT_W    = $clog2(LR_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [RADDR_W-1:0] push_dest,
    input  logic [DATA_W-1:0]  push_data,
    input  logic               pop,
    output logic [RADDR_W-1:0] head_dest,
    output logic [DATA_W-1:0]  head_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = $clog2(LR_DEPTH);

    logic [RADDR_W-1:0] dest_mem [LR_DEPTH];
    logic [DATA_W-1:0]  data_mem [LR_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(LR_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage is not reset; count==0 already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            dest_mem[wr_ptr] <= push_dest;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_dest = dest_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/wb_stage_arb.sv
// Writeback stage: MEM->WB slot, value mux with load extraction, and the register-file
// write port shared between in-order pipeline results and the late-result FIFO.
module wb_stage_arb
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int LR_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    wb_stage_arb_if.slave bus
);
    localparam int CNT_W = $clog2(LR_DEPTH) + 1;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic [RADDR_W-1:0] dest;
        logic [1:0]         wb_sel;
        logic [1:0]         ld_size;
        logic               ld_signed;
        logic [DATA_W-1:0]  alu_result;
        logic [DATA_W-1:0]  read_data;
        logic [DATA_W-1:0]  link_pc;
    } slot_t;

    slot_t              slot;
    logic               accept;
    logic               push;
    logic               pop;
    logic               slot_wr;
    logic [DATA_W-1:0]  slot_value;
    logic [RADDR_W-1:0] head_dest;
    logic [DATA_W-1:0]  head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Holding off the pipeline while the FIFO is full empties the slot, so the FIFO drains next cycle.
    assign bus.in_ready = (fifo_count != CNT_W'(LR_DEPTH));
    assign bus.lr_ready = ~fifo_full;
    assign accept       = bus.in_valid & bus.in_ready;
    assign push         = bus.lr_valid & bus.lr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot <= '0;
        end else if (accept) begin
            slot <= '{valid:      1'b1,
                      reg_write:  bus.in_reg_write,
                      dest:       bus.in_reg_dest,
                      wb_sel:     bus.in_wb_sel,
                      ld_size:    bus.in_ld_size,
                      ld_signed:  bus.in_ld_signed,
                      alu_result: bus.in_alu_result,
                      read_data:  bus.in_read_data,
                      link_pc:    bus.in_link_pc};
        end else begin
            slot.valid <= 1'b0;
        end
    end

    always_comb begin
        case (slot.wb_sel)
            WB_MEM:  slot_value = DATA_W'(ld_extract(MAX_W'(slot.read_data), slot.alu_result[1:0],
                                                     slot.ld_size, slot.ld_signed));
            WB_LINK: slot_value = slot.link_pc;
            default: slot_value = slot.alu_result;
        endcase
    end

    wb_late_fifo #(
        .DATA_W   (DATA_W),
        .RADDR_W  (RADDR_W),
        .LR_DEPTH (LR_DEPTH)
    ) u_late_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_dest (bus.lr_dest),
        .push_data (bus.lr_data),
        .pop       (pop),
        .head_dest (head_dest),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        slot_wr         = slot.valid & slot.reg_write;
        pop             = 1'b0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.wb_src_late = 1'b0;
        if (slot_wr) begin
            bus.wb_we   = (slot.dest != '0);
            bus.wb_addr = slot.dest;
            bus.wb_data = slot_value;
        end else if (!fifo_empty) begin
            // r0-destined entries still pop so they cannot clog the FIFO.
            pop             = 1'b1;
            bus.wb_we       = (head_dest != '0);
            bus.wb_addr     = head_dest;
            bus.wb_data     = head_data;
            bus.wb_src_late = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage_arb.sv
// Scoreboard bench for wb_stage_arb: directed stimulus pushes expected writes, a monitor checks them.
module tb_wb_stage_arb;
    import wb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [DW-1:0] RD_WORD = 32'h80FF_7F01;
    localparam logic [DW-1:0] LINK_PC = 32'h1000_0004;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_stage_arb_if #(.DATA_W(DW), .RADDR_W(AW)) bus ();

    wb_stage_arb #(.DATA_W(DW), .RADDR_W(AW), .LR_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]    sel;
        logic [1:0]    size;
        logic          sgn;
        logic [DW-1:0] alu;
        logic [AW-1:0] dest;
        logic [DW-1:0] exp;
    } ld_vec_t;

    exp_t    pipe_q[$];
    exp_t    late_q[$];
    exp_t    mon_e;
    ld_vec_t lv[12];
    int      total = 0;
    int      bad   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_alu_result = '0;
        bus.in_read_data  = RD_WORD;
        bus.in_link_pc    = LINK_PC;
        bus.in_wb_sel     = 2'd0;
        bus.in_reg_write  = 1'b0;
        bus.in_reg_dest   = '0;
        bus.in_ld_size    = 2'd0;
        bus.in_ld_signed  = 1'b0;
        bus.lr_valid      = 1'b0;
        bus.lr_dest       = '0;
        bus.lr_data       = '0;
    endtask

    task automatic drive_alu(input logic [AW-1:0] dest, input logic [DW-1:0] val, input logic we);
        bus.in_valid      = 1'b1;
        bus.in_wb_sel     = 2'd0;
        bus.in_reg_write  = we;
        bus.in_reg_dest   = dest;
        bus.in_alu_result = val;
        bus.in_ld_size    = 2'd0;
    endtask

    task automatic drive_late(input logic [AW-1:0] dest, input logic [DW-1:0] val);
        bus.lr_valid = 1'b1;
        bus.lr_dest  = dest;
        bus.lr_data  = val;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},       DW'(bus.wb_we),       '0);
        check({tag, "_addr"},     DW'(bus.wb_addr),     '0);
        check({tag, "_data"},     bus.wb_data,          '0);
        check({tag, "_src_late"}, DW'(bus.wb_src_late), '0);
        check({tag, "_in_ready"}, DW'(bus.in_ready),    DW'(1));
        check({tag, "_lr_ready"}, DW'(bus.lr_ready),    DW'(1));
    endtask

    // Monitor: every register-file write must match the head of the queue for its source.
    always @(negedge clk) begin
        if (bus.wb_we === 1'b1) begin
            if (bus.wb_src_late) begin
                if (late_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL late_unexpected: got write r%0d=0x%08h required no write",
                             bus.wb_addr, bus.wb_data);
                end else begin
                    mon_e = late_q.pop_front();
                    check("late_addr", DW'(bus.wb_addr), DW'(mon_e.addr));
                    check("late_data", bus.wb_data, mon_e.data);
                end
            end else begin
                if (pipe_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pipe_unexpected: got write r%0d=0x%08h required no write",
                             bus.wb_addr, bus.wb_data);
                end else begin
                    mon_e = pipe_q.pop_front();
                    check("pipe_addr", DW'(bus.wb_addr), DW'(mon_e.addr));
                    check("pipe_data", bus.wb_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        // read_data bytes: b0=01 b1=7F b2=FF b3=80; halves: h0=7F01 h1=80FF
        lv[0]  = '{2'd1, 2'd2, 1'b1, 32'h0000_0103, 5'd3,  32'hFFFF_FF80};
        lv[1]  = '{2'd1, 2'd2, 1'b0, 32'h0000_0103, 5'd4,  32'h0000_0080};
        lv[2]  = '{2'd1, 2'd1, 1'b1, 32'h0000_0102, 5'd6,  32'hFFFF_80FF};
        lv[3]  = '{2'd1, 2'd0, 1'b0, 32'h0000_0100, 5'd8,  32'h80FF_7F01};
        lv[4]  = '{2'd1, 2'd2, 1'b0, 32'h0000_0101, 5'd12, 32'h0000_007F};
        lv[5]  = '{2'd1, 2'd1, 1'b1, 32'h0000_0100, 5'd13, 32'h0000_7F01};
        lv[6]  = '{2'd2, 2'd0, 1'b0, 32'h0000_0200, 5'd10, 32'h1000_0004};
        lv[7]  = '{2'd3, 2'd0, 1'b0, 32'hCAFE_0000, 5'd14, 32'hCAFE_0000};
        lv[8]  = '{2'd1, 2'd3, 1'b1, 32'h0000_0103, 5'd15, 32'h80FF_7F01};
        lv[9]  = '{2'd1, 2'd2, 1'b1, 32'h0000_0102, 5'd16, 32'hFFFF_FFFF};
        lv[10] = '{2'd1, 2'd1, 1'b0, 32'h0000_0103, 5'd17, 32'h0000_80FF};
        lv[11] = '{2'd0, 2'd2, 1'b1, 32'h1234_5678, 5'd18, 32'h1234_5678};

        idle_inputs();
        #1;
        check_reset_outputs("in_reset");
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_reset_outputs("idle");
        end

        // Value mux and load extraction, back-to-back
        for (int i = 0; i < 12; i++) begin
            bus.in_valid      = 1'b1;
            bus.in_reg_write  = 1'b1;
            bus.in_wb_sel     = lv[i].sel;
            bus.in_ld_size    = lv[i].size;
            bus.in_ld_signed  = lv[i].sgn;
            bus.in_alu_result = lv[i].alu;
            bus.in_reg_dest   = lv[i].dest;
            pipe_q.push_back('{lv[i].dest, lv[i].exp});
            step();
            check("load_src_late", DW'(bus.wb_src_late), '0);
        end
        idle_inputs();
        repeat (2) step();

        // Fill: pipeline writes r5 every cycle, late results for r9 pile up
        for (int i = 0; i < 4; i++) begin
            check("fill_in_ready", DW'(bus.in_ready), DW'(1));
            check("fill_lr_ready", DW'(bus.lr_ready), DW'(1));
            drive_alu(5'd5, 32'h5000 + i, 1'b1);
            drive_late(5'd9, 32'h9000 + i);
            pipe_q.push_back('{5'd5, 32'h5000 + i});
            late_q.push_back('{5'd9, 32'h9000 + i});
            step();
        end
        check("full_lr_ready", DW'(bus.lr_ready), '0);
        check("full_in_ready", DW'(bus.in_ready), '0);
        step();
        check("drain_we",       DW'(bus.wb_we),       DW'(1));
        check("drain_src_late", DW'(bus.wb_src_late), DW'(1));
        check("drain_addr",     DW'(bus.wb_addr),     DW'(9));
        check("drain_in_ready", DW'(bus.in_ready),    '0);
        idle_inputs();
        step();
        check("count3_in_ready", DW'(bus.in_ready),    DW'(1));
        check("count3_lr_ready", DW'(bus.lr_ready),    DW'(1));
        check("count3_src_late", DW'(bus.wb_src_late), DW'(1));
        repeat (3) step();
        check("drained_we", DW'(bus.wb_we), '0);

        // Push and pop in the same cycle keep the count at one
        for (int k = 0; k < 3; k++) begin
            check("pp_lr_ready", DW'(bus.lr_ready), DW'(1));
            drive_late(5'd11, 32'hB0 + k);
            late_q.push_back('{5'd11, 32'hB0 + k});
            step();
            check("pp_src_late", DW'(bus.wb_src_late), DW'(1));
        end
        idle_inputs();
        step();
        check("pp_empty_we", DW'(bus.wb_we), '0);

        // Non-writing slot lets the FIFO head through in the same cycle
        drive_alu(5'd12, 32'h5555, 1'b0);
        drive_late(5'd7, 32'h1234);
        late_q.push_back('{5'd7, 32'h1234});
        step();
        idle_inputs();
        check("r7_we",       DW'(bus.wb_we),       DW'(1));
        check("r7_addr",     DW'(bus.wb_addr),     DW'(7));
        check("r7_data",     bus.wb_data,          32'h1234);
        check("r7_src_late", DW'(bus.wb_src_late), DW'(1));
        step();
        check("r7_popped_we", DW'(bus.wb_we), '0);

        // Register 0 is never written on either path
        drive_alu(5'd0, 32'hDEAD, 1'b1);
        step();
        idle_inputs();
        check("r0_pipe_we", DW'(bus.wb_we), '0);
        step();
        drive_late(5'd0, 32'hBEEF);
        step();
        idle_inputs();
        check("r0_late_we", DW'(bus.wb_we), '0);
        step();
        check("r0_late_popped", DW'(bus.wb_src_late), '0);
        check("r0_late_popped_we", DW'(bus.wb_we), '0);

        // Asynchronous reset with three FIFO entries and a writing slot
        for (int i = 0; i < 3; i++) begin
            drive_alu(5'd5, 32'h7000 + i, 1'b1);
            drive_late(5'd9, 32'hA000 + i);
            if (i < 2) pipe_q.push_back('{5'd5, 32'h7000 + i});
            step();
        end
        check("pre_reset_we", DW'(bus.wb_we), DW'(1));
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        idle_inputs();
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_reset_we", DW'(bus.wb_we), '0);
        end

        check("pipe_q_left", DW'(pipe_q.size()), '0);
        check("late_q_left", DW'(late_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
